// File: rtl/axi_pkg.sv
// Shared AXI4 constants, the arsize helper and the read-master state encoding.
package axi_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int AXI_4K_BYTES = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } rd_state_t;

    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi_burst_calc.sv
// Burst sizing: beats = min(remaining, MAX_BURST, words left before the next 4 KB boundary).
module axi_burst_calc
    import axi_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 32
) (
    input  logic [11:0]      addr_lo,
    input  logic [LEN_W-1:0] remaining,
    output logic [8:0]       beats,
    output logic [7:0]       arlen
);

    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int CW      = (LEN_W > 13) ? LEN_W : 13;

    logic [12:0]   to_4k;
    logic [CW-1:0] room;
    logic [CW-1:0] rem_w;
    logic [CW-1:0] pick;

    always_comb begin
        to_4k = (13'(AXI_4K_BYTES) - {1'b0, addr_lo}) >> BYTE_SH;
        room  = (CW'(to_4k) < CW'(MAX_BURST)) ? CW'(to_4k) : CW'(MAX_BURST);
        rem_w = CW'(remaining);
        pick  = (rem_w < room) ? rem_w : room;
        // pick never exceeds MAX_BURST (<= 256), so 9 bits hold it
        beats = 9'(pick);
        arlen = 8'(beats - 9'd1);
    end

endmodule

// File: rtl/axi_burst_read_master.sv
// AXI4 read master: splits one word-count request into INCR bursts (MAX_BURST cap,
// no 4 KB crossing) and streams read data to the consumer with full backpressure.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for read_en_in
// ST_ADDR | arvalid high, araddr/arlen held until arready
// ST_DATA | draining the single outstanding burst, counting beats
// ST_DONE | one-cycle done pulse, then back to IDLE
module axi_burst_read_master
    import axi_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_addr_in,
    input  logic [LEN_W-1:0]  read_len_in,
    input  logic              read_en_in,
    output logic              read_busy_out,
    output logic              read_done_out,
    output logic              read_error_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic              read_valid_out,
    input  logic              read_ready_in,
    output logic [ADDR_W-1:0] m00_axi_araddr,
    output logic [7:0]        m00_axi_arlen,
    output logic [2:0]        m00_axi_arsize,
    output logic [1:0]        m00_axi_arburst,
    output logic              m00_axi_arlock,
    output logic [3:0]        m00_axi_arcache,
    output logic [2:0]        m00_axi_arprot,
    output logic [3:0]        m00_axi_arqos,
    output logic              m00_axi_arvalid,
    input  logic              m00_axi_arready,
    input  logic [DATA_W-1:0] m00_axi_rdata,
    input  logic [1:0]        m00_axi_rresp,
    input  logic              m00_axi_rlast,
    input  logic              m00_axi_rvalid,
    output logic              m00_axi_rready
);

    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(DATA_W / 8 - 1);

    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic [8:0]        burst_beats_q;
    logic [8:0]        beat_cnt_q;
    logic              error_q;
    logic [8:0]        calc_beats;
    logic [7:0]        calc_arlen;
    logic              start_acc;
    logic              ar_fire;
    logic              r_fire;
    logic              last_beat;

    axi_burst_calc #(
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST),
        .LEN_W     (LEN_W)
    ) u_calc (
        .addr_lo   (addr_q[11:0]),
        .remaining (remaining_q),
        .beats     (calc_beats),
        .arlen     (calc_arlen)
    );

    assign start_acc = (state == ST_IDLE) && read_en_in;
    assign ar_fire   = (state == ST_ADDR) && m00_axi_arready;
    assign r_fire    = (state == ST_DATA) && m00_axi_rvalid && read_ready_in;
    assign last_beat = (beat_cnt_q == burst_beats_q - 9'd1);

    assign m00_axi_araddr  = addr_q;
    assign m00_axi_arsize  = axi_size(DATA_W);
    assign m00_axi_arburst = BURST_INCR;
    assign m00_axi_arlock  = 1'b0;
    assign m00_axi_arcache = 4'b0011;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arqos   = 4'b0000;
    assign read_data_out   = m00_axi_rdata;
    assign read_error_out  = error_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        m00_axi_arvalid = 1'b0;
        m00_axi_arlen   = '0;
        m00_axi_rready  = 1'b0;
        read_valid_out  = 1'b0;
        read_busy_out   = 1'b0;
        read_done_out   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (read_en_in) begin
                    state_nxt = (read_len_in != '0) ? ST_ADDR : ST_DONE;
                end
            end
            ST_ADDR: begin
                m00_axi_arvalid = 1'b1;
                m00_axi_arlen   = calc_arlen;
                read_busy_out   = 1'b1;
                if (m00_axi_arready) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                m00_axi_rready = read_ready_in;
                read_valid_out = m00_axi_rvalid;
                read_busy_out  = 1'b1;
                // the counted beat, not rlast, closes the burst
                if (r_fire && last_beat) begin
                    state_nxt = (remaining_q != '0) ? ST_ADDR : ST_DONE;
                end
            end
            ST_DONE: begin
                read_done_out = 1'b1;
                state_nxt     = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q        <= '0;
            remaining_q   <= '0;
            burst_beats_q <= '0;
            beat_cnt_q    <= '0;
            error_q       <= 1'b0;
        end else begin
            if (start_acc) begin
                addr_q      <= read_addr_in & ALIGN_MASK;
                remaining_q <= read_len_in;
                error_q     <= 1'b0;
            end
            if (ar_fire) begin
                addr_q        <= addr_q + (ADDR_W'(calc_beats) << BYTE_SH);
                remaining_q   <= remaining_q - LEN_W'(calc_beats);
                burst_beats_q <= calc_beats;
                beat_cnt_q    <= '0;
            end
            if (r_fire) begin
                beat_cnt_q <= beat_cnt_q + 9'd1;
                if ((m00_axi_rresp != RESP_OKAY) || (m00_axi_rlast != last_beat)) begin
                    error_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_read_master.sv
// Directed bench: reactive AXI slave model, burst/4 KB splitting, backpressure, errors, reset.
module tb_axi_burst_read_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [31:0] read_addr_in = '0;
    logic [31:0] read_len_in = '0;
    logic        read_en_in = 1'b0;
    logic        read_busy_out, read_done_out, read_error_out;
    logic [31:0] read_data_out;
    logic        read_valid_out;
    logic        read_ready_in = 1'b1;
    logic [31:0] m00_axi_araddr;
    logic [7:0]  m00_axi_arlen;
    logic [2:0]  m00_axi_arsize;
    logic [1:0]  m00_axi_arburst;
    logic        m00_axi_arlock;
    logic [3:0]  m00_axi_arcache;
    logic [2:0]  m00_axi_arprot;
    logic [3:0]  m00_axi_arqos;
    logic        m00_axi_arvalid;
    logic        m00_axi_arready = 1'b0;
    logic [31:0] m00_axi_rdata = '0;
    logic [1:0]  m00_axi_rresp = 2'b00;
    logic        m00_axi_rlast = 1'b0;
    logic        m00_axi_rvalid = 1'b0;
    logic        m00_axi_rready;

    // 64-bit instance: always-ready slave, only its AR sequence is checked
    logic [31:0] w_addr = '0;
    logic [31:0] w_len = '0;
    logic        w_en = 1'b0;
    logic        w_busy, w_done, w_error, w_valid;
    logic [63:0] w_data;
    logic [31:0] w_araddr;
    logic [7:0]  w_arlen;
    logic [2:0]  w_arsize;
    logic [1:0]  w_arburst;
    logic        w_arlock;
    logic [3:0]  w_arcache;
    logic [2:0]  w_arprot;
    logic [3:0]  w_arqos;
    logic        w_arvalid;
    logic        w_rready;

    int n_checks = 0;
    int n_err = 0;

    logic [39:0] ar_q[$];
    logic [39:0] ar64_q[$];
    logic [31:0] rx_q[$];
    int sl_left = 0;
    logic [31:0] sl_addr = '0;
    int g_beat = 0;
    int err_beat = -1;
    int early_beat = -1;
    int ar_delay = 0;
    int ar_wait = 0;
    bit ready_mode = 0;
    int arv_cnt = 0;
    int stab_err = 0;
    int overlap_err = 0;
    int mirror_err = 0;

    always #5 clk = ~clk;

    axi_burst_read_master #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(16), .LEN_W(32)) dut (
        .clk(clk), .rst(rst),
        .read_addr_in(read_addr_in), .read_len_in(read_len_in), .read_en_in(read_en_in),
        .read_busy_out(read_busy_out), .read_done_out(read_done_out),
        .read_error_out(read_error_out), .read_data_out(read_data_out),
        .read_valid_out(read_valid_out), .read_ready_in(read_ready_in),
        .m00_axi_araddr(m00_axi_araddr), .m00_axi_arlen(m00_axi_arlen),
        .m00_axi_arsize(m00_axi_arsize), .m00_axi_arburst(m00_axi_arburst),
        .m00_axi_arlock(m00_axi_arlock), .m00_axi_arcache(m00_axi_arcache),
        .m00_axi_arprot(m00_axi_arprot), .m00_axi_arqos(m00_axi_arqos),
        .m00_axi_arvalid(m00_axi_arvalid), .m00_axi_arready(m00_axi_arready),
        .m00_axi_rdata(m00_axi_rdata), .m00_axi_rresp(m00_axi_rresp),
        .m00_axi_rlast(m00_axi_rlast), .m00_axi_rvalid(m00_axi_rvalid),
        .m00_axi_rready(m00_axi_rready)
    );

    axi_burst_read_master #(.ADDR_W(32), .DATA_W(64), .MAX_BURST(16), .LEN_W(32)) dut64 (
        .clk(clk), .rst(rst),
        .read_addr_in(w_addr), .read_len_in(w_len), .read_en_in(w_en),
        .read_busy_out(w_busy), .read_done_out(w_done),
        .read_error_out(w_error), .read_data_out(w_data),
        .read_valid_out(w_valid), .read_ready_in(1'b1),
        .m00_axi_araddr(w_araddr), .m00_axi_arlen(w_arlen),
        .m00_axi_arsize(w_arsize), .m00_axi_arburst(w_arburst),
        .m00_axi_arlock(w_arlock), .m00_axi_arcache(w_arcache),
        .m00_axi_arprot(w_arprot), .m00_axi_arqos(w_arqos),
        .m00_axi_arvalid(w_arvalid), .m00_axi_arready(1'b1),
        .m00_axi_rdata(64'h0), .m00_axi_rresp(2'b00),
        .m00_axi_rlast(1'b0), .m00_axi_rvalid(1'b1),
        .m00_axi_rready(w_rready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ar(input string tag, input int idx, input logic [31:0] a, input logic [7:0] l);
        logic [39:0] obs;
        obs = (idx < ar_q.size()) ? ar_q[idx] : 'x;
        chk(tag, obs, {a, l});
    endtask

    task automatic chk_stream(input string tag, input logic [31:0] base, input int n);
        int bad = 0;
        chk({tag, "_count"}, rx_q.size(), n);
        for (int k = 0; k < rx_q.size(); k++) begin
            if (rx_q[k] !== base + 32'(4 * k)) bad++;
        end
        chk({tag, "_order"}, bad, 0);
    endtask

    // Environment: sample at negedge, drive slave inputs #1 after posedge
    initial begin
        logic ar_fire_s, r_fire_s, arv_s, ar_seen;
        logic [31:0] ar_addr_s, hold_addr;
        logic [7:0] ar_len_s, hold_len;
        ar_seen = 0;
        hold_addr = '0;
        hold_len = '0;
        forever begin
            @(negedge clk);
            arv_s = m00_axi_arvalid;
            ar_fire_s = m00_axi_arvalid && m00_axi_arready;
            r_fire_s = m00_axi_rvalid && m00_axi_rready;
            ar_addr_s = m00_axi_araddr;
            ar_len_s = m00_axi_arlen;
            if (arv_s) begin
                arv_cnt++;
                if (sl_left != 0) overlap_err++;
                if (!ar_seen) begin
                    ar_seen = 1;
                    hold_addr = ar_addr_s;
                    hold_len = ar_len_s;
                end else if (hold_addr !== ar_addr_s || hold_len !== ar_len_s) begin
                    stab_err++;
                end
            end
            if (read_valid_out && read_ready_in) rx_q.push_back(read_data_out);
            if (m00_axi_rvalid && (m00_axi_rready !== read_ready_in || read_valid_out !== 1'b1 ||
                                   read_data_out !== m00_axi_rdata)) mirror_err++;
            if (w_arvalid) ar64_q.push_back({w_araddr, w_arlen});
            @(posedge clk);
            #1;
            if (!rst) begin
                sl_left = 0;
                m00_axi_arready = 0;
                m00_axi_rvalid = 0;
                m00_axi_rlast = 0;
                m00_axi_rresp = 2'b00;
                ar_wait = 0;
                ar_seen = 0;
            end else begin
                if (ar_fire_s) begin
                    ar_q.push_back({ar_addr_s, ar_len_s});
                    sl_left = int'(ar_len_s) + 1;
                    sl_addr = ar_addr_s;
                    m00_axi_arready = 0;
                    ar_wait = 0;
                    ar_seen = 0;
                end else if (arv_s) begin
                    if (ar_wait >= ar_delay) m00_axi_arready = 1;
                    else ar_wait++;
                end
                if (r_fire_s) begin
                    g_beat++;
                    sl_left--;
                    sl_addr += 4;
                end
                m00_axi_rvalid = (sl_left != 0);
                m00_axi_rdata = sl_addr;
                m00_axi_rresp = (g_beat == err_beat) ? 2'b10 : 2'b00;
                m00_axi_rlast = (sl_left == 1) || (g_beat == early_beat);
                read_ready_in = ready_mode ? ~read_ready_in : 1'b1;
            end
        end
    end

    task automatic run_req(input logic [31:0] a, input logic [31:0] n, input bit poke,
                           output int cyc, output logic err, output logic busy1, output logic arv1);
        bit done;
        done = 0;
        ar_q.delete();
        rx_q.delete();
        g_beat = 0;
        arv_cnt = 0;
        read_addr_in = a;
        read_len_in = n;
        read_en_in = 1;
        @(posedge clk);
        #1;
        read_en_in = 0;
        cyc = 0;
        err = 'x;
        busy1 = 'x;
        arv1 = 'x;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                busy1 = read_busy_out;
                arv1 = m00_axi_arvalid;
            end
            if (read_done_out) begin
                done = 1;
                err = read_error_out;
            end else if (poke) begin
                read_en_in = (cyc == 3);
            end
        end
        read_en_in = 0;
        chk("done_seen", done, 1);
        @(negedge clk);
        chk("done_one_cycle", read_done_out, 0);
        chk("idle_after_done", read_busy_out, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic err, busy1, arv1;
        bit w_done_seen;

        #1;
        chk("rst_arvalid", m00_axi_arvalid, 0);
        chk("rst_araddr", m00_axi_araddr, 0);
        chk("rst_arlen", m00_axi_arlen, 0);
        chk("rst_busy", read_busy_out, 0);
        chk("rst_done", read_done_out, 0);
        chk("rst_error", read_error_out, 0);
        chk("arburst", m00_axi_arburst, 2'b01);
        chk("arcache", m00_axi_arcache, 4'b0011);
        chk("arsize32", m00_axi_arsize, 3'd2);
        chk("arsize64", w_arsize, 3'd3);
        repeat (2) @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;

        // single burst
        run_req(32'h1000, 8, 0, cyc, err, busy1, arv1);
        chk("t1_busy", busy1, 1);
        chk("t1_arvalid_next", arv1, 1);
        chk("t1_nbursts", ar_q.size(), 1);
        chk_ar("t1_ar0", 0, 32'h1000, 8'd7);
        chk_stream("t1", 32'h1000, 8);
        chk("t1_err", err, 0);

        // MAX_BURST splitting, a start pulse while busy must be ignored
        run_req(32'h0, 40, 1, cyc, err, busy1, arv1);
        chk("t2_nbursts", ar_q.size(), 3);
        chk_ar("t2_ar0", 0, 32'h000, 8'd15);
        chk_ar("t2_ar1", 1, 32'h040, 8'd15);
        chk_ar("t2_ar2", 2, 32'h080, 8'd7);
        chk_stream("t2", 32'h0, 40);
        chk("t2_overlap", overlap_err, 0);
        chk("t2_err", err, 0);

        // 4 KB boundary
        run_req(32'h0FF8, 4, 0, cyc, err, busy1, arv1);
        chk("t3_nbursts", ar_q.size(), 2);
        chk_ar("t3_ar0", 0, 32'h0FF8, 8'd1);
        chk_ar("t3_ar1", 1, 32'h1000, 8'd1);
        chk_stream("t3", 32'h0FF8, 4);

        // consumer backpressure 1010..., slow arready
        ready_mode = 1;
        ar_delay = 5;
        run_req(32'h2000, 20, 0, cyc, err, busy1, arv1);
        ready_mode = 0;
        ar_delay = 0;
        chk_ar("t4_ar0", 0, 32'h2000, 8'd15);
        chk_ar("t4_ar1", 1, 32'h2040, 8'd3);
        chk_stream("t4", 32'h2000, 20);
        chk("t4_arvalid_cycles", arv_cnt, 14);
        chk("t4_ar_stable", stab_err, 0);
        chk("t4_rready_mirror", mirror_err, 0);
        chk("t4_err", err, 0);

        // SLVERR on the third beat
        err_beat = 2;
        run_req(32'h3000, 8, 0, cyc, err, busy1, arv1);
        err_beat = -1;
        chk_stream("t5", 32'h3000, 8);
        chk("t5_err", err, 1);

        // rlast on the fifth beat
        early_beat = 4;
        run_req(32'h3100, 8, 0, cyc, err, busy1, arv1);
        early_beat = -1;
        chk_stream("t6", 32'h3100, 8);
        chk("t6_err", err, 1);

        // clean request clears the sticky error
        run_req(32'h0100, 8, 0, cyc, err, busy1, arv1);
        chk_stream("t7", 32'h0100, 8);
        chk("t7_err", err, 0);

        // zero length
        run_req(32'h5000, 0, 0, cyc, err, busy1, arv1);
        chk("t8_done_latency", cyc, 1);
        chk("t8_no_arvalid", arv_cnt, 0);
        chk("t8_err", err, 0);

        // unaligned start address
        run_req(32'h1003, 2, 0, cyc, err, busy1, arv1);
        chk_ar("t9_ar0", 0, 32'h1000, 8'd1);
        chk_stream("t9", 32'h1000, 2);

        // asynchronous reset during the first burst
        ar_q.delete();
        rx_q.delete();
        g_beat = 0;
        read_addr_in = 32'h4000;
        read_len_in = 16;
        read_en_in = 1;
        @(posedge clk);
        #1;
        read_en_in = 0;
        cyc = 0;
        while (g_beat < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("t10_reached_beat4", g_beat, 4);
        chk("t10_busy_before", read_busy_out, 1);
        rst = 0;
        #1;
        chk("t10_arvalid", m00_axi_arvalid, 0);
        chk("t10_araddr", m00_axi_araddr, 0);
        chk("t10_arlen", m00_axi_arlen, 0);
        chk("t10_busy", read_busy_out, 0);
        chk("t10_done", read_done_out, 0);
        chk("t10_error", read_error_out, 0);
        chk("t10_rready", m00_axi_rready, 0);
        chk("t10_valid", read_valid_out, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        chk("t10_idle", read_busy_out, 0);
        run_req(32'h4000, 16, 0, cyc, err, busy1, arv1);
        chk_ar("t10_ar0", 0, 32'h4000, 8'd15);
        chk_stream("t10", 32'h4000, 16);
        chk("t10_err", err, 0);

        // 64-bit data path: 4 KB split in 8-byte words
        ar64_q.delete();
        w_addr = 32'h0FF0;
        w_len = 4;
        w_en = 1;
        @(posedge clk);
        #1;
        w_en = 0;
        w_done_seen = 0;
        cyc = 0;
        while (!w_done_seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (w_done) w_done_seen = 1;
        end
        chk("t11_done", w_done_seen, 1);
        chk("t11_nbursts", ar64_q.size(), 2);
        chk("t11_ar0", (ar64_q.size() > 0) ? ar64_q[0] : 'x, {32'h0FF0, 8'd1});
        chk("t11_ar1", (ar64_q.size() > 1) ? ar64_q[1] : 'x, {32'h1000, 8'd1});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
